mux_arbiter_rr: RTL and testbench

- Round-robin, packet-aware arbiter that sits directly upstream of mux_pipeline and drives its `sel` input.
- Grants one of INPUT_COUNT requesters and holds the grant until that requester's last beat.
- Delays the accept strobe and selection through a LATENCY-deep shift register, so the downstream consumer gets a valid/sel tag aligned with the mux `out` data.

---
 rtl/mux_arbiter_rr.sv | 160 ++++++++++++++++
 tb/tb_mux_arbiter_rr.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mux_arbiter_rr.sv
// Packet-aware round-robin arbiter driving a mux select, with a valid/sel tag delayed to match mux latency.
// Optional idle-lock watchdog enabled by defining MUX_ARBITER_TIMEOUT_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant outstanding; first request at/after ptr wins
// BUSY  | grant locked to sel until its last beat (or watchdog)
module mux_arbiter_rr #(
    parameter int INPUT_COUNT = 4,
    parameter int LATENCY     = 0,
    parameter int TIMEOUT     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [INPUT_COUNT-1:0]         req,
    input  logic [INPUT_COUNT-1:0]         last,
    input  logic                           ready,
    output logic [INPUT_COUNT-1:0]         grant,
    output logic [$clog2(INPUT_COUNT)-1:0] sel,
    output logic                           out_valid,
    output logic [$clog2(INPUT_COUNT)-1:0] out_sel,
    output logic                           timeout
);

    localparam int SW = $clog2(INPUT_COUNT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state, state_nxt;
    logic [SW-1:0]          ptr, ptr_nxt, sel_nxt, sel_inc, arb_base, arb_win;
    logic [INPUT_COUNT-1:0] grant_nxt;
    logic                   arb_found, xfer, release_lock, wd_fire;

    if (INPUT_COUNT < 2 || TIMEOUT < 1) begin : g_param_check
        $error("mux_arbiter_rr: INPUT_COUNT must be >= 2 and TIMEOUT >= 1");
    end

    assign xfer         = (state == BUSY) & req[sel] & ready;
    assign sel_inc      = (sel == SW'(INPUT_COUNT - 1)) ? '0 : sel + 1'b1;
    assign release_lock = (xfer & last[sel]) | wd_fire;
    assign arb_base     = (state == BUSY) ? sel_inc : ptr;

    // Scan from arb_base upward with wrap; the index never exceeds INPUT_COUNT-1.
    always_comb begin
        int idx;
        idx       = 0;
        arb_found = 1'b0;
        arb_win   = '0;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            idx = int'(arb_base) + i;
            if (idx >= INPUT_COUNT) idx = idx - INPUT_COUNT;
            if (!arb_found && req[SW'(idx)]) begin
                arb_found = 1'b1;
                arb_win   = SW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    state_nxt = BUSY;
                    grant_nxt = INPUT_COUNT'(1) << arb_win;
                    sel_nxt   = arb_win;
                end
            end
            BUSY: begin
                if (release_lock) begin
                    ptr_nxt = sel_inc;
                    if (arb_found) begin
                        grant_nxt = INPUT_COUNT'(1) << arb_win;
                        sel_nxt   = arb_win;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        sel_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                sel_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
        end
    end

`ifdef MUX_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_cnt;
    logic          timeout_q;

    // Fires on the TIMEOUT-th consecutive cycle the granted source has req low.
    assign wd_fire = (state == BUSY) & ~req[sel] & (wd_cnt == TW'(TIMEOUT - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_fire;
            if (state != BUSY || xfer || release_lock) begin
                wd_cnt <= '0;
            end else if (!req[sel]) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    if (LATENCY == 0) begin : g_lat0
        assign out_valid = xfer;
        assign out_sel   = sel;
    end else begin : g_pipe
        logic [LATENCY-1:0] vld_q;
        logic [SW-1:0]      sel_q [LATENCY];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < LATENCY; i++) sel_q[i] <= '0;
            end else begin
                vld_q[0] <= xfer;
                sel_q[0] <= sel;
                for (int i = 1; i < LATENCY; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    sel_q[i] <= sel_q[i-1];
                end
            end
        end

        assign out_valid = vld_q[LATENCY-1];
        assign out_sel   = sel_q[LATENCY-1];
    end

endmodule

// File: tb/tb_mux_arbiter_rr.sv
// Directed bench for mux_arbiter_rr (INPUT_COUNT=4, LATENCY=2, TIMEOUT=8).
// Timeout expectations follow MUX_ARBITER_TIMEOUT_EN when it is defined for the build.
module tb_mux_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] last = '0;
    logic       ready = 1'b0;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       out_valid;
    logic [1:0] out_sel;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    mux_arbiter_rr #(.INPUT_COUNT(4), .LATENCY(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .ready(ready),
        .grant(grant), .sel(sel), .out_valid(out_valid), .out_sel(out_sel),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".grant"}, 32'(grant), 0);
        chk({tag, ".sel"}, 32'(sel), 0);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk({tag, ".out_sel"}, 32'(out_sel), 0);
        chk({tag, ".timeout"}, 32'(timeout), 0);
    endtask

    // Drive one cycle of inputs, clock once, check post-edge outputs.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l, input logic rd,
                        input logic [3:0] eg, input logic [1:0] es, input logic ev,
                        input logic [1:0] eos, input logic et);
        req   = r;
        last  = l;
        ready = rd;
        tick();
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".sel"}, 32'(sel), 32'(es));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        if (ev) chk({tag, ".out_sel"}, 32'(out_sel), 32'(eos));
        chk({tag, ".timeout"}, 32'(timeout), 32'(et));
    endtask

    initial begin
        logic [3:0] eg6;
        logic [1:0] es6;
        logic       et6;

        #1 rst_n = 1'b0;
        #1 chk_zero("reset");
        tick();
        rst_n = 1'b1;

        // 1: alternating grant between sources 0 and 2
        req = 4'b0101; last = 4'b1111; ready = 1'b1;
        do_reset();
        step("t1.e1", 4'b0101, 4'b1111, 1, 4'b0001, 0, 0, 0, 0);
        step("t1.e2", 4'b0101, 4'b1111, 1, 4'b0100, 2, 0, 0, 0);
        step("t1.e3", 4'b0101, 4'b1111, 1, 4'b0001, 0, 1, 0, 0);
        step("t1.e4", 4'b0101, 4'b1111, 1, 4'b0100, 2, 1, 2, 0);
        step("t1.e5", 4'b0101, 4'b1111, 1, 4'b0001, 0, 1, 0, 0);
        step("t1.e6", 4'b0101, 4'b1111, 1, 4'b0100, 2, 1, 2, 0);

        // 2: packet lock, source 0 three beats then source 1 with no gap
        do_reset();
        step("t2.e1", 4'b0011, 4'b0010, 1, 4'b0001, 0, 0, 0, 0);
        step("t2.e2", 4'b0011, 4'b0010, 1, 4'b0001, 0, 0, 0, 0);
        step("t2.e3", 4'b0011, 4'b0010, 1, 4'b0001, 0, 1, 0, 0);
        step("t2.e4", 4'b0011, 4'b0011, 1, 4'b0010, 1, 1, 0, 0);
        step("t2.e5", 4'b0011, 4'b0010, 1, 4'b0001, 0, 1, 0, 0);
        step("t2.e6", 4'b0000, 4'b0000, 1, 4'b0001, 0, 1, 1, 0);
        step("t2.e7", 4'b0000, 4'b0000, 1, 4'b0001, 0, 0, 0, 0);

        // 3: backpressure mid-packet on source 1
        do_reset();
        step("t3.e1", 4'b0010, 4'b0000, 1, 4'b0010, 1, 0, 0, 0);
        step("t3.e2", 4'b0010, 4'b0000, 1, 4'b0010, 1, 0, 0, 0);
        step("t3.e3", 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 1, 0);
        step("t3.e4", 4'b0010, 4'b0000, 0, 4'b0010, 1, 0, 0, 0);
        step("t3.e5", 4'b0010, 4'b0000, 1, 4'b0010, 1, 0, 0, 0);
        step("t3.e6", 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 1, 0);
        step("t3.e7", 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 1, 0);

        // 4: fairness wrap with everyone requesting single-beat packets
        do_reset();
        step("t4.e1", 4'b1111, 4'b1111, 1, 4'b0001, 0, 0, 0, 0);
        step("t4.e2", 4'b1111, 4'b1111, 1, 4'b0010, 1, 0, 0, 0);
        step("t4.e3", 4'b1111, 4'b1111, 1, 4'b0100, 2, 1, 0, 0);
        step("t4.e4", 4'b1111, 4'b1111, 1, 4'b1000, 3, 1, 1, 0);
        step("t4.e5", 4'b1111, 4'b1111, 1, 4'b0001, 0, 1, 2, 0);
        step("t4.e6", 4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 3, 0);

        // 5: asynchronous reset with beats in flight
        do_reset();
        step("t5.e1", 4'b0011, 4'b0000, 1, 4'b0001, 0, 0, 0, 0);
        step("t5.e2", 4'b0011, 4'b0000, 1, 4'b0001, 0, 0, 0, 0);
        step("t5.e3", 4'b0011, 4'b0000, 1, 4'b0001, 0, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        req = 4'b1000;
        #1 chk_zero("t5.async");
        tick();
        chk("t5.in_reset.grant", 32'(grant), 0);
        rst_n = 1'b1;
        step("t5.r1", 4'b1001, 4'b0000, 1, 4'b0001, 0, 0, 0, 0);
        step("t5.r2", 4'b1001, 4'b0000, 1, 4'b0001, 0, 0, 0, 0);

        // 6: granted source 2 goes quiet while source 3 waits
        do_reset();
        step("t6.e1", 4'b0100, 4'b0000, 1, 4'b0100, 2, 0, 0, 0);
        for (int k = 2; k <= 10; k++) begin
`ifdef MUX_ARBITER_TIMEOUT_EN
            eg6 = (k >= 9) ? 4'b1000 : 4'b0100;
            es6 = (k >= 9) ? 2'd3 : 2'd2;
            et6 = (k == 9);
`else
            eg6 = 4'b0100;
            es6 = 2'd2;
            et6 = 1'b0;
`endif
            step($sformatf("t6.e%0d", k), 4'b1000, 4'b0000, 1, eg6, es6, 0, 0, et6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
